// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: DIGIT bits per cycle through a DIGIT-wide ripple,
// with the carry held in a register between digit cycles and valid/ready on both sides.
module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one digit per edge, N edges
    // DONE  | result held, out_valid high until out_ready

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_add_sub: DIGIT must lie in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] b_in;
    logic             carry_q;
    logic             msb_a_q;
    logic             msb_b_q;
    logic [CW-1:0]    cnt_q;
    logic             last_digit;
    logic [DIGIT-1:0] dsum;
    logic             ripple_c;

    assign b_in       = sub ? ~b : b;
    assign last_digit = (cnt_q == CW'(N - 1));

    always_comb begin
        dsum     = '0;
        ripple_c = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ ripple_c;
            ripple_c = (a_q[i] & b_q[i]) | (ripple_c & (a_q[i] ^ b_q[i]));
        end
    end

    // Completed digit enters at the top so the LSB digit ends at bit 0 after N shifts.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= sub | cin;
                        msb_a_q <= a[WIDTH-1];
                        msb_b_q <= b_in[WIDTH-1];
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_next;
                    carry_q <= ripple_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_digit) begin
                        sum  <= acc_next;
                        cout <= ripple_c;
                        ovf  <= (msb_a_q == msb_b_q) && (acc_next[WIDTH-1] != msb_a_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
